// File: rtl/jpeg_stream_sequencer.sv
// jpeg_stream_sequencer
// Frame sequencer for one JPEG output frame: SOI marker, fixed header from an
// external header memory, entropy-coded data passed through an external byte
// stuffer, stuffer flush, then the EOI marker. All words leave on a single
// 16-bit downstream stream with a byte mask and a zero-latency handshake.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start                 begin a frame (sampled only while idle)
//   busy, frame_done      status; frame_done pulses on the EOI transfer
//   byte_count            valid bytes sent downstream in the current frame
//   hdr_addr, hdr_data    header memory address / combinational read data
//   enc_in/valid/last/rdy encoder word stream
//   stuf_*                byte stuffer control, data and status pins
//   out, out_valid        downstream word and byte mask (11 both, 10 upper)
//   ena_out, rdy_in       downstream transfer strobe and ready
module jpeg_stream_sequencer #(
    parameter int unsigned HDR_WORDS = 8,
    parameter int unsigned HDR_AW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic [31:0]       byte_count,
    output logic [HDR_AW-1:0] hdr_addr,
    input  logic [15:0]       hdr_data,
    input  logic [15:0]       enc_in,
    input  logic              enc_valid,
    input  logic              enc_last,
    output logic              enc_rdy,
    output logic              stuf_rst,
    output logic [15:0]       stuf_in,
    output logic              stuf_ena_in,
    output logic              stuf_rdy_in,
    output logic              stuf_flush,
    input  logic              stuf_rdy_out,
    input  logic              stuf_ena_out,
    input  logic              stuf_done,
    input  logic [15:0]       stuf_out,
    input  logic [1:0]        stuf_out_valid,
    output logic [15:0]       out,
    output logic [1:0]        out_valid,
    output logic              ena_out,
    input  logic              rdy_in
);

    localparam logic [15:0]       SOI_MARKER = 16'hFFD8;
    localparam logic [15:0]       EOI_MARKER = 16'hFFD9;
    localparam logic [HDR_AW-1:0] HDR_LAST   = HDR_AW'(HDR_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SOI,
        S_HDR,
        S_DATA,
        S_FLUSH,
        S_EOI
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        hdr_adv;
    logic        hdr_wrap;
    logic [31:0] byte_inc;
    logic        frame_start;

    // Encoder data goes straight to the stuffer; ena_in qualifies it.
    assign stuf_in     = enc_in;
    assign frame_start = (state == S_IDLE) && start;

    // Bytes carried by the word currently on the downstream bus.
    always_comb begin
        byte_inc = 32'd0;
        if (out_valid == 2'b11) begin
            byte_inc = 32'd2;
        end else if (out_valid == 2'b10) begin
            byte_inc = 32'd1;
        end
    end

    // State, header address and byte counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            byte_count <= 32'd0;
            hdr_addr   <= '0;
        end else begin
            state <= next_state;
            if (frame_start) begin
                byte_count <= 32'd0;
            end else if (ena_out) begin
                byte_count <= byte_count + byte_inc;
            end
            if (frame_start) begin
                hdr_addr <= '0;
            end else if (hdr_adv) begin
                hdr_addr <= hdr_wrap ? '0 : hdr_addr + HDR_AW'(1);
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        next_state  = state;
        busy        = (state != S_IDLE);
        frame_done  = 1'b0;
        enc_rdy     = 1'b0;
        ena_out     = 1'b0;
        stuf_ena_in = 1'b0;
        stuf_rdy_in = 1'b0;
        stuf_flush  = 1'b0;
        stuf_rst    = (state == S_CLEAR);
        out         = 16'h0000;
        out_valid   = 2'b00;
        hdr_adv     = 1'b0;
        hdr_wrap    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                next_state = S_SOI;
            end
            S_SOI: begin
                out       = SOI_MARKER;
                out_valid = 2'b11;
                ena_out   = rdy_in;
                if (rdy_in) begin
                    next_state = S_HDR;
                end
            end
            S_HDR: begin
                out       = hdr_data;
                out_valid = 2'b11;
                ena_out   = rdy_in;
                hdr_adv   = rdy_in;
                if (rdy_in && (hdr_addr == HDR_LAST)) begin
                    hdr_wrap   = 1'b1;
                    next_state = S_DATA;
                end
            end
            S_DATA: begin
                stuf_rdy_in = rdy_in;
                stuf_ena_in = enc_valid;
                enc_rdy     = stuf_rdy_out;
                out         = stuf_out;
                out_valid   = stuf_out_valid;
                // Gate with rdy_in so a stalled downstream never sees a strobe.
                ena_out     = stuf_ena_out & rdy_in;
                if (enc_valid && stuf_rdy_out && enc_last) begin
                    next_state = S_FLUSH;
                end
            end
            S_FLUSH: begin
                stuf_flush  = 1'b1;
                stuf_rdy_in = rdy_in;
                if (stuf_done) begin
                    next_state = S_EOI;
                end else begin
                    out       = stuf_out;
                    out_valid = stuf_out_valid;
                    ena_out   = stuf_ena_out & rdy_in;
                end
            end
            S_EOI: begin
                out       = EOI_MARKER;
                out_valid = 2'b11;
                ena_out   = rdy_in;
                if (rdy_in) begin
                    frame_done = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase

        // Reset forces idle-state outputs immediately and holds the stuffer in reset.
        if (rst) begin
            busy        = 1'b0;
            frame_done  = 1'b0;
            enc_rdy     = 1'b0;
            ena_out     = 1'b0;
            stuf_ena_in = 1'b0;
            stuf_rdy_in = 1'b0;
            stuf_flush  = 1'b0;
            stuf_rst    = 1'b1;
            out_valid   = 2'b00;
            hdr_adv     = 1'b0;
        end
    end

endmodule
